half_subtractor: RTL and testbench
==================================

# half_subtractor

Single-bit half subtractor with a registered shadow stage and a borrow-event counter. Combinational `difference`/`borrow` give a − b with zero latency for datapath use. A clocked stage captures qualified results for pipelined consumers and counts borrow events for debug/status. It sits at the leaf level of the arithmetic library, beneath full subtractors and ripple-borrow chains.

## Interface
- `CNT_W`, default 8: width of the saturating borrow-event counter (≥1).
- `clk`  input  1  single clock; all registered state is on its rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `a`  input  1  minuend bit.
- `b`  input  1  subtrahend bit.
- `in_valid`  input  1  qualifies `a`/`b` for the registered stage.
- `difference`  output  1  combinational a XOR b.
- `borrow`  output  1  combinational (NOT a) AND b.
- `diff_q`  output  1  registered difference.
- `borrow_q`  output  1  registered borrow.
- `out_valid`  output  1  `diff_q`/`borrow_q` hold a result captured on the previous edge.
- `borrow_cnt`  output  CNT_W  saturating count of accepted operations with borrow=1.
- `cnt_clr`  input  1  synchronous clear of `borrow_cnt`.

## Operation
- Truth table, {a,b} → {difference,borrow}: 00→00, 01→11, 10→10, 11→00.
- `difference`/`borrow` are purely combinational and independent of `clk`, `rst_n`, and `in_valid`. They stay valid during reset.
- Registered stage: on each rising edge with `in_valid`=1, `diff_q`/`borrow_q` ← current combinational results and `out_valid` ← 1. With `in_valid`=0, `out_valid` ← 0 and `diff_q`/`borrow_q` hold their values.
- Counter: on an edge with `in_valid`=1 and borrow=1, `borrow_cnt` increments and saturates at 2^CNT_W−1, with no wrap.
- `cnt_clr`=1 forces `borrow_cnt` ← 0 and takes priority over a simultaneous increment. The registered outputs are unaffected by `cnt_clr`.
- There are no handshake back-pressure semantics. Every valid input is accepted.

## Timing
- Combinational outputs: zero cycle latency, settle within one propagation delay of an `a`/`b` change.
- Registered outputs: one cycle latency from the edge sampling `in_valid`=1.
- `rst_n` low: immediately, without a clock, sets `diff_q`=0, `borrow_q`=0, `out_valid`=0, `borrow_cnt`=0.
- Reset mid-operation discards any in-flight result. The first edge after deassertion with `in_valid`=1 produces `out_valid`=1 on the following cycle.
- Reset deassertion is synchronized externally. The block requires no settling cycles.

## Structure
- Shared arithmetic package: `CNT_W` default constant, and a 2-bit `sub_result_t` struct {diff, borrow} reused by the full subtractor.
- Sub-module `half_subtractor_core`: pure combinational a,b → diff,borrow, reused by the full-subtractor block. The top adds the register stage and counter.

## Test plan
- Exhaustive combinational: apply {a,b}=00,01,10,11, 10 ns each, with no clock toggling → {difference,borrow}=00,11,10,00.
- Registered path: `in_valid`=1 with a=0,b=1 → next cycle `diff_q`=1, `borrow_q`=1, `out_valid`=1. Drop `in_valid` → `out_valid`=0 and values hold.
- Counter: 5 valid cycles of a=0,b=1 interleaved with 3 of a=1,b=0 → `borrow_cnt`=5. With CNT_W=2, 6 borrows → `borrow_cnt`=3, saturated.
- Clear priority: `cnt_clr`=1 coincident with a valid borrow → `borrow_cnt`=0 next cycle.
- Async reset: assert `rst_n`=0 between clock edges with `out_valid`=1 → all registered outputs 0 immediately, while `difference`/`borrow` still track a,b.

Source files
------------

// File: rtl/half_subtractor_pkg.sv
// Shared arithmetic types for the subtractor library.
// Result bundle and default widths used by half/full subtractors.
package half_subtractor_pkg;

  localparam int CNT_W_DEF = 8;

  typedef struct packed {
    logic diff;
    logic borrow;
  } sub_result_t;

  function automatic sub_result_t hs_eval(
    input logic a,
    input logic b
  );
    sub_result_t r;
    r.diff   = a ^ b;
    r.borrow = ~a & b;
    return r;
  endfunction

endpackage

// File: rtl/half_subtractor_core.sv
// Combinational single-bit a - b.
// Reused unchanged inside the full-subtractor block.
module half_subtractor_core
  import half_subtractor_pkg::*;
(
  input  logic        a,
  input  logic        b,
  output sub_result_t res
);

  assign res = hs_eval(a, b);

endmodule

// File: rtl/half_subtractor.sv
// Half subtractor with registered shadow stage
// and saturating borrow-event counter.
module half_subtractor
  import half_subtractor_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             in_valid,
  input  logic             cnt_clr,
  output logic             difference,
  output logic             borrow,
  output logic             diff_q,
  output logic             borrow_q,
  output logic             out_valid,
  output logic [CNT_W-1:0] borrow_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  sub_result_t      res;
  sub_result_t      res_q;
  logic             cnt_inc;
  logic             cnt_sat;
  logic [CNT_W-1:0] cnt_nxt;

  half_subtractor_core u_core (
    .a   (a),
    .b   (b),
    .res (res)
  );

  assign difference = res.diff;
  assign borrow     = res.borrow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) res_q <= res;
    end
  end

  assign diff_q   = res_q.diff;
  assign borrow_q = res_q.borrow;

  assign cnt_inc = in_valid & res.borrow;
  assign cnt_sat = (borrow_cnt == CNT_MAX);

  // clear wins over a coincident increment
  always_comb begin
    cnt_nxt = borrow_cnt;
    unique case (1'b1)
      cnt_clr: cnt_nxt = '0;
      (!cnt_clr && cnt_inc && !cnt_sat):
        cnt_nxt = borrow_cnt + 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) borrow_cnt <= '0;
    else        borrow_cnt <= cnt_nxt;
  end

endmodule

// File: tb/tb_half_subtractor.sv
// Self-checking bench for half_subtractor (CNT_W=8 and CNT_W=2).
// Table vectors, directed corners and randomized model compare.
module tb_half_subtractor;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst_n;
  logic       a, b, in_valid, cnt_clr;
  logic       d8, b8, dq8, bq8, ov8;
  logic       d2, b2, dq2, bq2, ov2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  int vectors = 0;
  int miscompares = 0;

  int m_dq, m_bq, m_ov, m_c8, m_c2;

  typedef struct {
    logic a;
    logic b;
    logic d;
    logic bo;
  } vec_t;

  vec_t tbl [4];

  always #5 if (clk_en) clk = ~clk;

  half_subtractor #(.CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b),
    .in_valid(in_valid), .cnt_clr(cnt_clr),
    .difference(d8), .borrow(b8),
    .diff_q(dq8), .borrow_q(bq8),
    .out_valid(ov8), .borrow_cnt(cnt8)
  );

  half_subtractor #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b),
    .in_valid(in_valid), .cnt_clr(cnt_clr),
    .difference(d2), .borrow(b2),
    .diff_q(dq2), .borrow_q(bq2),
    .out_valid(ov2), .borrow_cnt(cnt2)
  );

  task automatic check(
    input string nm,
    input int    act,
    input int    exp
  );
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d",
               nm, act, exp);
    end
  endtask

  function automatic int ref_diff(input int x, input int y);
    return (x - y) & 1;
  endfunction

  function automatic int ref_bor(input int x, input int y);
    return (x < y) ? 1 : 0;
  endfunction

  task automatic chk_comb();
    check("difference8", int'(d8), ref_diff(a, b));
    check("borrow8", int'(b8), ref_bor(a, b));
    check("difference2", int'(d2), ref_diff(a, b));
    check("borrow2", int'(b2), ref_bor(a, b));
  endtask

  task automatic chk_regs();
    check("diff_q8", int'(dq8), m_dq);
    check("borrow_q8", int'(bq8), m_bq);
    check("out_valid8", int'(ov8), m_ov);
    check("borrow_cnt8", int'(cnt8), m_c8);
    check("diff_q2", int'(dq2), m_dq);
    check("borrow_q2", int'(bq2), m_bq);
    check("out_valid2", int'(ov2), m_ov);
    check("borrow_cnt2", int'(cnt2), m_c2);
  endtask

  task automatic model_reset();
    m_dq = 0; m_bq = 0; m_ov = 0;
    m_c8 = 0; m_c2 = 0;
  endtask

  // drive at negedge, capture at posedge, check next negedge
  task automatic cyc(
    input logic ia,
    input logic ib,
    input logic iv,
    input logic ic
  );
    int bo;
    a = ia; b = ib; in_valid = iv; cnt_clr = ic;
    @(negedge clk);
    bo = ref_bor(ia, ib);
    m_ov = iv;
    if (iv) begin
      m_dq = ref_diff(ia, ib);
      m_bq = bo;
    end
    if (ic) begin
      m_c8 = 0; m_c2 = 0;
    end else if (iv && bo == 1) begin
      m_c8 = (m_c8 + 1 > 255) ? 255 : m_c8 + 1;
      m_c2 = (m_c2 + 1 > 3) ? 3 : m_c2 + 1;
    end
    chk_regs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0};

    rst_n = 1'b0; a = 0; b = 0;
    in_valid = 0; cnt_clr = 0;
    model_reset();
    #3;
    chk_regs();

    // combinational under reset, clock stopped
    for (int i = 0; i < 4; i++) begin
      a = tbl[i].a; b = tbl[i].b;
      #10;
      check("tbl_diff", int'(d8), int'(tbl[i].d));
      check("tbl_borrow", int'(b8), int'(tbl[i].bo));
      check("tbl_diff2", int'(d2), int'(tbl[i].d));
      check("tbl_borrow2", int'(b2), int'(tbl[i].bo));
    end
    rst_n = 1'b1;
    #10;
    for (int i = 0; i < 4; i++) begin
      a = tbl[i].a; b = tbl[i].b;
      #10;
      check("tbl_diff_nr", int'(d8), int'(tbl[i].d));
      check("tbl_borrow_nr", int'(b8), int'(tbl[i].bo));
    end
    check("no_clk_out_valid", int'(ov8), 0);

    clk_en = 1'b1;
    @(negedge clk);

    // registered path and hold
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    check("reg_diff_q", int'(dq8), 1);
    check("reg_borrow_q", int'(bq8), 1);
    check("reg_out_valid", int'(ov8), 1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("hold_out_valid", int'(ov8), 0);
    check("hold_diff_q", int'(dq8), 1);
    check("hold_borrow_q", int'(bq8), 1);

    // 5 borrows interleaved with 3 non-borrows
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 1 && i < 6) cyc(1'b1, 1'b0, 1'b1, 1'b0);
      else                     cyc(1'b0, 1'b1, 1'b1, 1'b0);
    end
    check("cnt_five", int'(cnt8), 5);

    // saturation on the 2-bit instance
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++)
      cyc(1'b0, 1'b1, 1'b1, 1'b0);
    check("cnt2_sat", int'(cnt2), 3);
    check("cnt8_six", int'(cnt8), 6);

    // clear beats a coincident borrow
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    check("clr_prio8", int'(cnt8), 0);
    check("clr_prio2", int'(cnt2), 0);
    check("clr_keeps_ov", int'(ov8), 1);

    // randomized against the model
    for (int i = 0; i < 300; i++) begin
      cyc(1'($urandom_range(1)), 1'($urandom_range(1)),
          1'($urandom_range(3) != 0),
          1'($urandom_range(31) == 0));
      chk_comb();
    end

    // async reset between edges
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    check("pre_rst_ov", int'(ov8), 1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_regs();
    a = 1'b1; b = 1'b0;
    #1;
    chk_comb();
    a = 1'b0; b = 1'b1;
    #1;
    chk_comb();
    @(negedge clk);
    chk_regs();
    rst_n = 1'b1;
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    check("post_rst_ov", int'(ov8), 1);
    check("post_rst_diff_q", int'(dq8), 1);
    check("post_rst_cnt", int'(cnt8), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
